// File: rtl/store_buffer.sv
// Circular store buffer. Stores are allocated in order, filled by execute,
// committed by the ROB, drained to memory in order, and forwarded to loads.
module store_buffer #(
  parameter int SB_ENTRY = 8,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  output logic [$clog2(SB_ENTRY)-1:0] alloc_idx_o,
  input  logic                        exe_valid_i,
  input  logic [$clog2(SB_ENTRY)-1:0] exe_idx_i,
  input  logic [ADDR_W-1:0]           exe_addr_i,
  input  logic [DATA_W-1:0]           exe_data_i,
  input  logic                        rob_sb_valid_i,
  input  logic                        rob_mispredict_i,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_data_o,
  input  logic [ADDR_W-1:0]           ld_addr_i,
  output logic                        ld_hit_o,
  output logic [DATA_W-1:0]           ld_data_o,
  output logic                        sb_empty_o
);

  localparam int IDX_W = $clog2(SB_ENTRY);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(SB_ENTRY);

  logic [SB_ENTRY-1:0] ent_vld, ent_fill, ent_cmt;
  logic [SB_ENTRY-1:0] vld_nxt, fill_nxt, cmt_nxt;
  logic [ADDR_W-1:0]   ent_addr [SB_ENTRY];
  logic [DATA_W-1:0]   ent_data [SB_ENTRY];
  logic [IDX_W-1:0]    head, cmt, tail, age_idx;
  logic [IDX_W:0]      count, count_nxt, cmt_cnt;
  logic                alloc_fire, exe_we, commit_fire, drain_fire;

  assign alloc_ready_o = (count != FULL_CNT) & ~rob_mispredict_i;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  assign exe_we        = exe_valid_i & ~rob_mispredict_i
                         & ent_vld[exe_idx_i] & ~ent_cmt[exe_idx_i];
  assign commit_fire   = rob_sb_valid_i & ~rob_mispredict_i;
  assign mem_valid_o   = ent_vld[head] & ent_cmt[head];
  assign drain_fire    = mem_valid_o & mem_ready_i;
  // Data arrays are not reset, so the drain port is zeroed while idle.
  assign mem_addr_o    = mem_valid_o ? ent_addr[head] : '0;
  assign mem_data_o    = mem_valid_o ? ent_data[head] : '0;
  assign sb_empty_o    = (count == '0);
  assign alloc_idx_o   = tail;

  // Committed-but-undrained entries survive a flush; count them directly
  // because head == cmt is ambiguous when all entries are committed.
  always_comb begin
    cmt_cnt = '0;
    for (int i = 0; i < SB_ENTRY; i++)
      cmt_cnt = cmt_cnt + (IDX_W+1)'(ent_vld[i] & ent_cmt[i]);
  end

  always_comb begin
    vld_nxt  = ent_vld;
    fill_nxt = ent_fill;
    cmt_nxt  = ent_cmt;
    if (alloc_fire) begin
      vld_nxt[tail]  = 1'b1;
      fill_nxt[tail] = 1'b0;
      cmt_nxt[tail]  = 1'b0;
    end
    if (exe_we)      fill_nxt[exe_idx_i] = 1'b1;
    if (commit_fire) cmt_nxt[cmt] = 1'b1;
    if (drain_fire)  vld_nxt[head] = 1'b0;
    if (rob_mispredict_i) begin
      vld_nxt  = vld_nxt & ent_cmt;
      fill_nxt = fill_nxt & ent_cmt;
    end
    if (rob_mispredict_i)
      count_nxt = cmt_cnt - (IDX_W+1)'(drain_fire);
    else
      count_nxt = count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(drain_fire);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ent_vld  <= '0;
      ent_fill <= '0;
      ent_cmt  <= '0;
      head     <= '0;
      cmt      <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      ent_vld  <= vld_nxt;
      ent_fill <= fill_nxt;
      ent_cmt  <= cmt_nxt;
      count    <= count_nxt;
      head     <= head + IDX_W'(drain_fire);
      cmt      <= cmt + IDX_W'(commit_fire);
      tail     <= rob_mispredict_i ? cmt : tail + IDX_W'(alloc_fire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (exe_we) begin
      ent_addr[exe_idx_i] <= exe_addr_i;
      ent_data[exe_idx_i] <= exe_data_i;
    end
  end

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    age_idx   = '0;
    for (int k = 0; k < SB_ENTRY; k++) begin
      age_idx = head + IDX_W'(k);
      if (ent_vld[age_idx] && ent_fill[age_idx] && ent_addr[age_idx] == ld_addr_i) begin
        ld_hit_o  = 1'b1;
        ld_data_o = ent_data[age_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; drained stores are checked against a
// scoreboard queue by an independent monitor.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_v, alloc_ready;
  logic [2:0]  alloc_idx;
  logic        exe_v;
  logic [2:0]  exe_idx;
  logic [15:0] exe_addr, exe_data;
  logic        rob_v, rob_mis;
  logic        mem_valid, mem_ready;
  logic [15:0] mem_addr, mem_data;
  logic [15:0] ld_addr;
  logic        ld_hit;
  logic [15:0] ld_data;
  logic        sb_empty;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  store_buffer #(.SB_ENTRY(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .alloc_valid_i(alloc_v), .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
    .exe_valid_i(exe_v), .exe_idx_i(exe_idx), .exe_addr_i(exe_addr), .exe_data_i(exe_data),
    .rob_sb_valid_i(rob_v), .rob_mispredict_i(rob_mis),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .ld_data_o(ld_data),
    .sb_empty_o(sb_empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted drain must match the oldest expected store.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL drain_unexpected: got %h expected no drain", {mem_addr, mem_data});
      end else begin
        mon_exp = exp_q.pop_front();
        check("drain", {mem_addr, mem_data}, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_v = 1'b0;
    exe_v   = 1'b0;
    rob_v   = 1'b0;
    rob_mis = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
    check({tag, "_alloc_idx"},   32'(alloc_idx),   32'd0);
    check({tag, "_mem_valid"},   32'(mem_valid),   32'd0);
    check({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
    check({tag, "_mem_data"},    32'(mem_data),    32'd0);
    check({tag, "_ld_hit"},      32'(ld_hit),      32'd0);
    check({tag, "_ld_data"},     32'(ld_data),     32'd0);
    check({tag, "_sb_empty"},    32'(sb_empty),    32'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    alloc_v = 1'b0; exe_v = 1'b0; exe_idx = '0; exe_addr = '0; exe_data = '0;
    rob_v = 1'b0; rob_mis = 1'b0; mem_ready = 1'b0; ld_addr = '0;
    exp_q.delete();
    #2;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic exe_write(input logic [2:0] idx, input logic [15:0] a, input logic [15:0] d);
    exe_v = 1'b1; exe_idx = idx; exe_addr = a; exe_data = d;
    tick();
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single store end to end
    do_reset("rst1");
    alloc_v = 1'b1;
    check("t1_idx", 32'(alloc_idx), 32'd0);
    tick();
    exe_write(3'd0, 16'h0010, 16'hBEEF);
    ld_addr = 16'h0010;
    #1;
    check("t1_ld_hit", 32'(ld_hit), 32'd1);
    check("t1_ld_data", 32'(ld_data), 32'hBEEF);
    check("t1_precommit_valid", 32'(mem_valid), 32'd0);
    mem_ready = 1'b1;
    rob_v = 1'b1;
    exp_q.push_back(32'h0010BEEF);
    tick();
    check("t1_mem_valid", 32'(mem_valid), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'h0010);
    check("t1_mem_data", 32'(mem_data), 32'hBEEF);
    tick();
    check("t1_empty", 32'(sb_empty), 32'd1);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Fill to capacity, stall, drain with a colliding alloc
    do_reset("rst2");
    for (int i = 0; i < 8; i++) begin
      check("t2_alloc_idx", 32'(alloc_idx), 32'(i));
      alloc_v = 1'b1;
      tick();
    end
    check("t2_full_ready", 32'(alloc_ready), 32'd0);
    check("t2_full_idx", 32'(alloc_idx), 32'd0);
    alloc_v = 1'b1;
    tick();
    check("t2_ninth_ready", 32'(alloc_ready), 32'd0);
    check("t2_ninth_idx", 32'(alloc_idx), 32'd0);
    for (int i = 0; i < 8; i++) exe_write(3'(i), 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      rob_v = 1'b1;
      exp_q.push_back({16'h0100 + 16'(i), 16'hA000 + 16'(i)});
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      check("t2_hold_valid", 32'(mem_valid), 32'd1);
      check("t2_hold_addr", 32'(mem_addr), 32'h0100);
      check("t2_hold_data", 32'(mem_data), 32'hA000);
      tick();
    end
    mem_ready = 1'b1;
    alloc_v = 1'b1;
    #1;
    check("t2_collide_ready", 32'(alloc_ready), 32'd0);
    tick();
    check("t2_after_ready", 32'(alloc_ready), 32'd1);
    check("t2_wrap_idx", 32'(alloc_idx), 32'd0);
    alloc_v = 1'b1;
    tick();
    check("t2_next_idx", 32'(alloc_idx), 32'd1);
    wait_drained("t2_drain_done");
    check("t2_head_blocked", 32'(mem_valid), 32'd0);
    check("t2_not_empty", 32'(sb_empty), 32'd0);
    rob_mis = 1'b1;
    tick();
    check("t2_flush_empty", 32'(sb_empty), 32'd1);
    check("t2_flush_idx", 32'(alloc_idx), 32'd0);

    // Mispredict keeps only committed entries
    do_reset("rst3");
    for (int i = 0; i < 3; i++) begin
      alloc_v = 1'b1;
      tick();
    end
    check("t3_idx3", 32'(alloc_idx), 32'd3);
    for (int i = 0; i < 3; i++) exe_write(3'(i), 16'h0030 + 16'(i), 16'h3000 + 16'(i));
    rob_v = 1'b1;
    exp_q.push_back(32'h00303000);
    tick();
    rob_mis = 1'b1;
    #1;
    check("t3_flush_ready", 32'(alloc_ready), 32'd0);
    tick();
    check("t3_tail", 32'(alloc_idx), 32'd1);
    check("t3_not_empty", 32'(sb_empty), 32'd0);
    ld_addr = 16'h0031;
    #1;
    check("t3_flushed_ld_hit", 32'(ld_hit), 32'd0);
    ld_addr = 16'h0030;
    #1;
    check("t3_kept_ld_hit", 32'(ld_hit), 32'd1);
    check("t3_kept_ld_data", 32'(ld_data), 32'h3000);
    mem_ready = 1'b1;
    wait_drained("t3_drain_done");
    check("t3_empty", 32'(sb_empty), 32'd1);
    check("t3_next_idx", 32'(alloc_idx), 32'd1);

    // Youngest-wins forwarding across the wrap point
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alloc_v = 1'b1;
      tick();
    end
    check("t3_wrap_full", 32'(alloc_ready), 32'd0);
    exe_write(3'd7, 16'h0040, 16'h7777);
    exe_write(3'd0, 16'h0040, 16'h8888);
    ld_addr = 16'h0040;
    #1;
    check("t3_wrap_ld_hit", 32'(ld_hit), 32'd1);
    check("t3_wrap_ld_data", 32'(ld_data), 32'h8888);

    // Two stores to the same address
    do_reset("rst4");
    for (int i = 0; i < 2; i++) begin
      alloc_v = 1'b1;
      tick();
    end
    exe_write(3'd0, 16'h0020, 16'h1111);
    exe_write(3'd1, 16'h0020, 16'h2222);
    ld_addr = 16'h0020;
    #1;
    check("t4_ld_hit", 32'(ld_hit), 32'd1);
    check("t4_ld_data", 32'(ld_data), 32'h2222);
    ld_addr = 16'h0021;
    #1;
    check("t4_miss_hit", 32'(ld_hit), 32'd0);
    check("t4_miss_data", 32'(ld_data), 32'd0);

    // Asynchronous reset while a store waits to drain
    do_reset("rst5");
    alloc_v = 1'b1;
    tick();
    exe_write(3'd0, 16'h0055, 16'h5555);
    ld_addr = 16'h0055;
    rob_v = 1'b1;
    tick();
    check("t5_pending_valid", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("t5_post_valid", 32'(mem_valid), 32'd0);
    check("t5_post_empty", 32'(sb_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_ENTRY, 8, number of store entries (power of 2).
REQ-002 SHALL have parameter ADDR_W, 16, memory address width.
REQ-003 SHALL have parameter DATA_W, 16, store data width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port alloc_valid_i  input  1  rename requests a store entry.
REQ-007 SHALL have port alloc_ready_o  output  1  a free entry exists and no flush is in progress.
REQ-008 SHALL have port alloc_idx_o  output  $clog2(SB_ENTRY)  index granted to the allocating store (tail pointer).
REQ-009 SHALL have port exe_valid_i  input  1  execution delivers a store's address and data.
REQ-010 SHALL have port exe_idx_i  input  $clog2(SB_ENTRY)  target entry for exe write.
REQ-011 SHALL have ports exe_addr_i / exe_data_i  input  ADDR_W / DATA_W  store address and data.
REQ-012 SHALL have port rob_sb_valid_i  input  1  ROB commits the oldest uncommitted store.
REQ-013 SHALL have port rob_mispredict_i  input  1  ROB flush; discard all uncommitted entries.
REQ-014 SHALL have ports mem_valid_o / mem_ready_i  output / input  1 / 1  drain handshake to data memory.
REQ-015 SHALL have ports mem_addr_o / mem_data_o  output  ADDR_W / DATA_W  oldest committed store.
REQ-016 SHALL have port ld_addr_i  input  ADDR_W  load lookup address for forwarding.
REQ-017 SHALL have ports ld_hit_o / ld_data_o  output  1 / DATA_W  forwarding result.
REQ-018 SHALL have port sb_empty_o  output  1  no valid entries.

Function
REQ-019 SHALL keep per-entry state valid, filled, committed, addr, data; three pointers head (drain), cmt (next to commit), tail (alloc), each wrapping modulo SB_ENTRY; plus count 0..SB_ENTRY (width $clog2(SB_ENTRY)+1).
REQ-020 SHALL drive alloc_ready_o = (count != SB_ENTRY) & ~rob_mispredict_i, from registered count only (no same-cycle drain bypass).
REQ-021 SHALL on alloc_valid_i & alloc_ready_o set entry[tail].valid=1, filled=0, committed=0, tail+1, count+1.
REQ-022 SHALL on exe_valid_i with entry[exe_idx_i].valid & ~committed write addr/data and set filled=1; otherwise ignore the write.
REQ-023 SHALL on rob_sb_valid_i & ~rob_mispredict_i set entry[cmt].committed=1 and cmt+1; commit of an unfilled or invalid entry is a protocol error (bench assertion), state still advances.
REQ-024 SHALL drive mem_valid_o = entry[head].valid & committed; mem_addr_o/mem_data_o from entry[head]; held stable until mem_ready_i.
REQ-025 SHALL on mem_valid_o & mem_ready_i clear entry[head].valid, head+1, count-1.
REQ-026 SHALL on rob_mispredict_i clear valid of every uncommitted entry, set tail=cmt, count=number of committed-undrained entries (accounting for a same-cycle drain); alloc, exe write and commit that cycle are ignored; draining continues.
REQ-027 SHALL allow alloc, exe write, commit and drain in the same cycle; count changes by (+1 alloc) (-1 drain).
REQ-028 SHALL compute ld_hit_o combinationally: 1 if any valid & filled entry has addr == ld_addr_i; ld_data_o = data of the youngest such entry (nearest tail in age order); ld_data_o = 0 when no hit.
REQ-029 SHALL drive sb_empty_o = (count == 0); alloc_idx_o = tail.

Reset
REQ-030 SHALL on reset_i low immediately (asynchronously) clear all valid/filled/committed bits, head=cmt=tail=0, count=0.
REQ-031 SHALL present after reset: alloc_ready_o=1, alloc_idx_o=0, mem_valid_o=0, mem_addr_o=0, mem_data_o=0, ld_hit_o=0, ld_data_o=0, sb_empty_o=1.
REQ-032 SHALL, if reset asserts mid-drain with mem_valid_o=1, drop mem_valid_o in the same cycle and lose the pending store.

Verification
REQ-033 SHALL cover: alloc idx0, exe addr=0x0010 data=0xBEEF, commit, mem_ready_i=1 -> mem_valid_o=1 with 0x0010/0xBEEF one cycle after commit, then sb_empty_o=1.
REQ-034 SHALL cover: 8 allocs without commit -> alloc_ready_o=0 after 8th; 9th alloc_valid_i ignored; alloc_idx_o wraps to 0 after drains.
REQ-035 SHALL cover: 3 allocs, commit 1, mispredict -> tail=1, count=1, only entry0 drains, next alloc_idx_o=1.
REQ-036 SHALL cover: two filled stores to 0x0020 data 0x1111 then 0x2222, ld_addr_i=0x0020 -> ld_hit_o=1, ld_data_o=0x2222.
REQ-037 SHALL cover: committed head with mem_ready_i=0 for 5 cycles -> mem_valid_o and data stable; full buffer with simultaneous drain and alloc -> alloc rejected that cycle (alloc_ready_o=0), accepted next.
REQ-038 SHALL cover: reset_i low mid-drain -> all outputs at REQ-031 values before next clock edge.
